// File: rtl/fb_ctrl_pkg.sv
// Shared types and helpers for the frame-buffer swap controller.
package fb_ctrl_pkg;

   typedef logic [1:0] buf_idx_t;

   localparam int MAX_BUF = 3;

   // Third buffer index, given two distinct indices from {0,1,2}.
   // The three indices sum to 3, so the missing one is 3 - a - b (mod 4).
   function automatic buf_idx_t other_idx(input buf_idx_t a, input buf_idx_t b);
      return buf_idx_t'(2'd3 - a - b);
   endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the VGA vsync into the fabric clock domain and flags the start of
// vertical blank as a one-cycle pulse on the synchronized falling edge.
module vs_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic vs_in,
   output logic vblank_start
);

   // [0],[1] are the two synchronizer stages, [2] holds the previous
   // synchronized value for edge detection. Reset to 1 (vsync idle) so
   // reset release cannot fake an edge.
   logic [2:0] sync_q, sync_d;

   // Next value of the synchronizer shift chain.
   always_comb begin
      sync_d = {sync_q[1:0], vs_in};
   end

   // Synchronizer and edge register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 3'b111;
      else       sync_q <= sync_d;
   end

   assign vblank_start = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/fb_swap_ctrl.sv
// Frame-buffer swap controller: hands a back buffer to the renderer and
// retargets scan-out only at vertical-blank start (double or triple buffer).
module fb_swap_ctrl
   import fb_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] FB0_BASE  = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] FB_STRIDE = 32'h0004_B000,
   parameter int                NUM_BUF   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_vs,
   input  logic              swap_en,
   input  logic              draw_done,
   output logic [ADDR_W-1:0] frame_buffer_ptr,
   output logic [ADDR_W-1:0] draw_ptr,
   output logic              draw_valid,
   output logic              swap_pulse,
   output logic [15:0]       frame_count,
   output logic [15:0]       drop_count
);

   localparam bit TRIPLE = (NUM_BUF == MAX_BUF);

   // Precomputed buffer base addresses; wraps modulo 2^ADDR_W.
   localparam logic [ADDR_W-1:0] ADDR_0 = FB0_BASE;
   localparam logic [ADDR_W-1:0] ADDR_1 = FB0_BASE + FB_STRIDE;
   localparam logic [ADDR_W-1:0] ADDR_2 = FB0_BASE + FB_STRIDE + FB_STRIDE;

   function automatic logic [ADDR_W-1:0] addr_of(input buf_idx_t idx);
      case (idx)
         2'd1:    return ADDR_1;
         2'd2:    return ADDR_2;
         default: return ADDR_0;
      endcase
   endfunction

   logic vblank_start;

   vs_edge_sync u_vs_sync (
      .clk          (clk),
      .reset        (reset),
      .vs_in        (vga_vs),
      .vblank_start (vblank_start)
   );

   buf_idx_t          disp_idx_q, disp_idx_d;
   buf_idx_t          draw_idx_q, draw_idx_d;
   buf_idx_t          pend_idx_q, pend_idx_d;
   logic              pend_vld_q, pend_vld_d;
   logic              draw_valid_q, draw_valid_d;
   logic              swap_pulse_q, swap_pulse_d;
   logic [ADDR_W-1:0] fb_ptr_q, fb_ptr_d;
   logic [ADDR_W-1:0] draw_ptr_q, draw_ptr_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic [15:0]       drop_count_q, drop_count_d;

   logic done_acc;
   logic do_swap;

   // Buffer ownership: accept finished frames, swap at vblank, pick new back buffer.
   always_comb begin
      disp_idx_d    = disp_idx_q;
      draw_idx_d    = draw_idx_q;
      pend_idx_d    = pend_idx_q;
      pend_vld_d    = pend_vld_q;
      draw_valid_d  = draw_valid_q;
      swap_pulse_d  = 1'b0;
      frame_count_d = frame_count_q;
      drop_count_d  = drop_count_q;

      done_acc = draw_done & draw_valid_q;
      do_swap  = vblank_start & swap_en & pend_vld_q;

      if (do_swap) begin
         disp_idx_d    = pend_idx_q;
         pend_vld_d    = 1'b0;
         swap_pulse_d  = 1'b1;
         frame_count_d = frame_count_q + 16'd1;
      end

      if (!TRIPLE) begin
         // Renderer can only finish while nothing is pending, so a swap
         // and an accepted done never coincide here.
         if (do_swap) begin
            draw_idx_d = disp_idx_q;
         end else if (done_acc) begin
            pend_idx_d = draw_idx_q;
            pend_vld_d = 1'b1;
         end
         draw_valid_d = ~pend_vld_d;
      end else begin
         if (done_acc) begin
            pend_idx_d = draw_idx_q;
            pend_vld_d = 1'b1;
            if (pend_vld_q && !do_swap) begin
               // Unshown pending frame is discarded and recycled for drawing.
               draw_idx_d   = pend_idx_q;
               drop_count_d = drop_count_q + 16'd1;
            end else begin
               // Old pending (if any) just went to display; take the free one.
               draw_idx_d = other_idx(disp_idx_d, draw_idx_q);
            end
         end
         draw_valid_d = ~done_acc;
      end

      fb_ptr_d   = addr_of(disp_idx_d);
      draw_ptr_d = addr_of(draw_idx_d);
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_idx_q    <= 2'd0;
         draw_idx_q    <= 2'd1;
         pend_idx_q    <= 2'd0;
         pend_vld_q    <= 1'b0;
         draw_valid_q  <= 1'b0;
         swap_pulse_q  <= 1'b0;
         fb_ptr_q      <= ADDR_0;
         draw_ptr_q    <= ADDR_1;
         frame_count_q <= 16'd0;
         drop_count_q  <= 16'd0;
      end else begin
         disp_idx_q    <= disp_idx_d;
         draw_idx_q    <= draw_idx_d;
         pend_idx_q    <= pend_idx_d;
         pend_vld_q    <= pend_vld_d;
         draw_valid_q  <= draw_valid_d;
         swap_pulse_q  <= swap_pulse_d;
         fb_ptr_q      <= fb_ptr_d;
         draw_ptr_q    <= draw_ptr_d;
         frame_count_q <= frame_count_d;
         drop_count_q  <= drop_count_d;
      end
   end

   assign frame_buffer_ptr = fb_ptr_q;
   assign draw_ptr         = draw_ptr_q;
   assign draw_valid       = draw_valid_q;
   assign swap_pulse       = swap_pulse_q;
   assign frame_count      = frame_count_q;
   assign drop_count       = drop_count_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench: double- and triple-buffer instances driven by the same random
// vsync / draw_done / swap_en stream, each checked against a buffer model.
module tb_fb_swap_ctrl;

   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] STRIDE = 32'h0004_B000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vga_vs = 1'b1;
   logic swap_en = 1'b1;
   logic draw_done = 1'b0;

   logic [31:0] fbp [2];
   logic [31:0] dptr [2];
   logic        dv [2];
   logic        sp [2];
   logic [15:0] fcnt [2];
   logic [15:0] dcnt [2];

   always #5 clk = ~clk;

   fb_swap_ctrl #(.ADDR_W(32), .FB0_BASE(BASE), .FB_STRIDE(STRIDE), .NUM_BUF(2)) u_dbl (
      .clk(clk), .reset(rst), .vga_vs(vga_vs), .swap_en(swap_en), .draw_done(draw_done),
      .frame_buffer_ptr(fbp[0]), .draw_ptr(dptr[0]), .draw_valid(dv[0]),
      .swap_pulse(sp[0]), .frame_count(fcnt[0]), .drop_count(dcnt[0])
   );

   fb_swap_ctrl #(.ADDR_W(32), .FB0_BASE(BASE), .FB_STRIDE(STRIDE), .NUM_BUF(3)) u_tri (
      .clk(clk), .reset(rst), .vga_vs(vga_vs), .swap_en(swap_en), .draw_done(draw_done),
      .frame_buffer_ptr(fbp[1]), .draw_ptr(dptr[1]), .draw_valid(dv[1]),
      .swap_pulse(sp[1]), .frame_count(fcnt[1]), .drop_count(dcnt[1])
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: which buffer is displayed / drawn / pending, per mode.
   int m_disp [2], m_draw [2], m_pend [2], m_fc [2], m_dc [2];
   bit m_pv [2], m_dv [2], m_sp [2];
   bit [2:0] vs_hist;   // vsync as seen at the last three edges, newest in [0]
   int lowrun [2];      // consecutive low cycles of draw_valid (triple check)

   function automatic int free_buf(input int a, input int b);
      for (int i = 0; i < 3; i++) if (i != a && i != b) return i;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            m_disp[m] = 0; m_draw[m] = 1; m_pend[m] = 0; m_pv[m] = 0;
            m_dv[m] = 0; m_sp[m] = 0; m_fc[m] = 0; m_dc[m] = 0;
         end
         vs_hist = 3'b111;
      end else begin
         // vblank is acted on at the third edge after vsync is first sampled low
         bit vb;
         vb = vs_hist[2] && !vs_hist[1];
         vs_hist = {vs_hist[1:0], vga_vs};
         for (int m = 0; m < 2; m++) begin
            bit done, swp;
            done = draw_done && m_dv[m];
            swp  = vb && swap_en && m_pv[m];
            m_sp[m] = swp;
            if (m == 0) begin
               if (swp) begin
                  int old_disp;
                  old_disp = m_disp[m];
                  m_disp[m] = m_pend[m]; m_draw[m] = old_disp; m_pv[m] = 0;
               end else if (done) begin
                  m_pend[m] = m_draw[m]; m_pv[m] = 1;
               end
               m_dv[m] = !m_pv[m];
            end else begin
               if (swp && done) begin
                  m_disp[m] = m_pend[m]; m_pend[m] = m_draw[m];
                  m_draw[m] = free_buf(m_disp[m], m_pend[m]);
               end else if (swp) begin
                  m_disp[m] = m_pend[m]; m_pv[m] = 0;
               end else if (done && m_pv[m]) begin
                  int t;
                  t = m_pend[m]; m_pend[m] = m_draw[m]; m_draw[m] = t;
                  m_dc[m]++;
               end else if (done) begin
                  m_pend[m] = m_draw[m]; m_pv[m] = 1;
                  m_draw[m] = free_buf(m_disp[m], m_pend[m]);
               end
               m_dv[m] = !done;
            end
            if (swp) m_fc[m]++;
         end
      end
   end

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         string p;
         p = (m == 0) ? "dbl" : "tri";
         chk({p, " fbp"},   fbp[m],  BASE + 32'(m_disp[m]) * STRIDE);
         chk({p, " dptr"},  dptr[m], BASE + 32'(m_draw[m]) * STRIDE);
         chk({p, " dv"},    32'(dv[m]), 32'(m_dv[m]));
         chk({p, " swap"},  32'(sp[m]), 32'(m_sp[m]));
         chk({p, " fcnt"},  32'(fcnt[m]), 32'(m_fc[m] & 16'hFFFF));
         chk({p, " dcnt"},  32'(dcnt[m]), 32'(m_dc[m] & 16'hFFFF));
         // identical stream: swap happens only when the display moves
         if (!rst && !dv[m]) lowrun[m]++; else lowrun[m] = 0;
         if (m == 1 && !rst) chk("tri dv low run <= 1", 32'(lowrun[m] > 1), 32'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk({tag, " fbp"},  fbp[m],  BASE);
         chk({tag, " dptr"}, dptr[m], BASE + STRIDE);
         chk({tag, " dv"},   32'(dv[m]), 32'd0);
         chk({tag, " swap"}, 32'(sp[m]), 32'd0);
         chk({tag, " fcnt"}, 32'(fcnt[m]), 32'd0);
         chk({tag, " dcnt"}, 32'(dcnt[m]), 32'd0);
      end
   endtask

   int vs_cnt = 0;
   int vs_period = 20;
   int vs_low = 3;
   int en_hold = 0;

   initial begin
      lowrun[0] = 0; lowrun[1] = 0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      #1;
      chk("dbl dv before first edge", 32'(dv[0]), 32'd0);
      @(negedge clk);
      chk("dbl dv after release", 32'(dv[0]), 32'd1);
      chk("tri dv after release", 32'(dv[1]), 32'd1);

      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         compare_all();
         if (cyc == 3000) begin
            // mid-frame async reset: outputs drop immediately, pending lost
            rst = 1'b1;
            #1;
            chk_reset_vals("midrst");
            @(negedge clk);
            compare_all();
            rst = 1'b0;
         end
         // vsync: periodic low pulse of 2..4 cycles, period 12..40
         vs_cnt++;
         if (vs_cnt >= vs_period) begin
            vs_cnt = 0;
            vs_period = $urandom_range(12, 40);
            vs_low = $urandom_range(2, 4);
         end
         vga_vs = (vs_cnt < vs_low) ? 1'b0 : 1'b1;
         // renderer finishes frames at random, sometimes while not owning a buffer
         draw_done = ($urandom_range(0, 5) == 0);
         // swap_en held low for long stretches spanning several vblanks
         if (en_hold > 0) en_hold--;
         else if ($urandom_range(0, 299) == 0) en_hold = $urandom_range(60, 150);
         swap_en = (en_hold == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
